// File: rtl/score_award_sequencer.sv
// score_award_sequencer
//   Collects multi-point awards from NREQ game sources and serialises them,
//   round-robin, into single-point score_inc pulses for the BCD score counter.
//   Optional feature macro: SCORE_SEQ_PACE_EN -- inserts GAP idle cycles after
//   every pulse. The default build (macro undefined) issues up to one pulse per
//   cycle and ignores GAP.
module score_award_sequencer #(
  parameter int NREQ = 3,
  parameter int PW   = 4,
  parameter int GAP  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     hold,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*PW-1:0]       req_pts,
  output logic [NREQ-1:0]          req_ready,
  output logic                     score_inc,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     busy
);

  localparam int IW = $clog2(NREQ);

  logic [PW-1:0] pending_q [NREQ];
  logic [PW-1:0] pending_d [NREQ];
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] grant_id_q;
  logic          score_inc_q;
  logic          busy_q, busy_d;
  logic [NREQ-1:0] elig;
  logic [IW-1:0] win;
  logic          found;
  logic          grant;
  logic          pace_ok;

  assign score_inc = score_inc_q;
  assign grant_id  = grant_id_q;
  assign busy      = busy_q;

`ifdef SCORE_SEQ_PACE_EN
  localparam int GW = (GAP < 1) ? 1 : $clog2(GAP + 1);
  logic [GW-1:0] pace_q, pace_d;

  assign pace_ok = (pace_q == '0);

  // Pace counter: reloads on every grant, keeps counting through hold.
  always_comb begin
    pace_d = pace_q;
    if (clear)
      pace_d = '0;
    else if (grant)
      pace_d = GW'(GAP);
    else if (pace_q != '0)
      pace_d = pace_q - GW'(1);
  end

  // Pace counter register.
  always_ff @(posedge clk) begin
    if (rst) pace_q <= '0;
    else     pace_q <= pace_d;
  end
`else
  assign pace_ok = 1'b1;
`endif

  // Round-robin winner search: first eligible index at or after rr_ptr,
  // falling back to the lowest eligible index below it (wrap-around).
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < NREQ; i++)
      elig[i] = (pending_q[i] != '0);
    for (int i = 0; i < NREQ; i++) begin
      if (!found && elig[i] && (i >= int'(rr_ptr_q))) begin
        found = 1'b1;
        win   = IW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && elig[i]) begin
        found = 1'b1;
        win   = IW'(i);
      end
    end
  end

  assign grant = found && !hold && !clear && pace_ok;

  // Next-state pending points, ready, busy and round-robin pointer.
  // A requester is only ready when its pending count is zero, so an accept
  // and a decrement can never hit the same slot in one cycle.
  always_comb begin
    busy_d = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = (pending_q[i] == '0) && !rst;
      pending_d[i] = pending_q[i];
      if (clear)
        pending_d[i] = '0;
      else if (grant && (win == IW'(i)))
        pending_d[i] = pending_q[i] - PW'(1);
      else if (req_valid[i] && (pending_q[i] == '0))
        pending_d[i] = req_pts[i*PW +: PW];
      busy_d = busy_d | (pending_d[i] != '0);
    end

    rr_ptr_d = rr_ptr_q;
    if (clear)
      rr_ptr_d = '0;
    else if (grant)
      rr_ptr_d = (win == IW'(NREQ - 1)) ? '0 : win + IW'(1);
  end

  // State and registered outputs; grant_id keeps the last served requester.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++)
        pending_q[i] <= '0;
      rr_ptr_q    <= '0;
      score_inc_q <= 1'b0;
      grant_id_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      rr_ptr_q    <= rr_ptr_d;
      score_inc_q <= grant;
      busy_q      <= busy_d;
      if (grant)
        grant_id_q <= win;
    end
  end

endmodule

// File: tb/tb_score_award_sequencer.sv
// Testbench for score_award_sequencer (NREQ=3, PW=4, GAP=2).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_score_award_sequencer;

  logic        clk = 1'b0;
  logic        rst, clear, hold;
  logic [2:0]  req_valid;
  logic [11:0] req_pts;
  logic [2:0]  req_ready;
  logic        score_inc;
  logic [1:0]  grant_id;
  logic        busy;

  int tests  = 0;
  int fails  = 0;
  int pulses = 0;

  typedef struct {
    logic [2:0]  v;
    logic [11:0] p;
    logic        h;
    logic        c;
    logic        inc;
    logic [1:0]  gid;
    logic        bsy;
    logic [2:0]  rdy;
  } vec_t;

  vec_t tbl[$];

  score_award_sequencer #(.NREQ(3), .PW(4), .GAP(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .hold      (hold),
    .req_valid (req_valid),
    .req_pts   (req_pts),
    .req_ready (req_ready),
    .score_inc (score_inc),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic [2:0] v, input logic [11:0] p,
                              input logic h, input logic c, input logic inc,
                              input logic [1:0] gid, input logic bsy,
                              input logic [2:0] rdy);
    vec_t r;
    r.v = v; r.p = p; r.h = h; r.c = c;
    r.inc = inc; r.gid = gid; r.bsy = bsy; r.rdy = rdy;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Apply inputs at a falling edge, advance one clock, count pulses seen.
  task automatic cyc(input logic [2:0] v, input logic [11:0] p, input logic h, input logic c);
    req_valid = v;
    req_pts   = p;
    hold      = h;
    clear     = c;
    @(negedge clk);
    if (score_inc) pulses++;
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; hold = 1'b0;
    req_valid = 3'b111; req_pts = 12'h555;
    @(negedge clk);
    chk("rst ready low c1", 32'(req_ready), 32'h0);
    @(negedge clk);
    chk("rst ready low c2", 32'(req_ready), 32'h0);
    chk("rst inc", 32'(score_inc), 32'h0);
    chk("rst busy", 32'(busy), 32'h0);
    rst = 1'b0;
    cyc(3'b000, 12'h000, 1'b0, 1'b0);
    chk("post-rst inc", 32'(score_inc), 32'h0);
    chk("post-rst busy", 32'(busy), 32'h0);
    chk("post-rst ready", 32'(req_ready), 32'h7);
    chk("post-rst gid", 32'(grant_id), 32'h0);
    pulses = 0;

`ifndef SCORE_SEQ_PACE_EN
    // Single award of 5 on requester 0.
    tbl.push_back(mk(3'b001, 12'h005, 0, 0, 0, 2'd0, 1, 3'b110));
    tbl.push_back(mk(3'b000, 12'h000, 0, 0, 1, 2'd0, 1, 3'b110));
    tbl.push_back(mk(3'b000, 12'h000, 0, 0, 1, 2'd0, 1, 3'b110));
    tbl.push_back(mk(3'b000, 12'h000, 0, 0, 1, 2'd0, 1, 3'b110));
    tbl.push_back(mk(3'b000, 12'h000, 0, 0, 1, 2'd0, 1, 3'b110));
    tbl.push_back(mk(3'b000, 12'h000, 0, 0, 1, 2'd0, 0, 3'b111));
    tbl.push_back(mk(3'b000, 12'h000, 0, 0, 0, 2'd0, 0, 3'b111));
    // Clear to restart the round-robin pointer, then 2/1/2 on all three.
    tbl.push_back(mk(3'b000, 12'h000, 0, 1, 0, 2'd0, 0, 3'b111));
    tbl.push_back(mk(3'b111, 12'h212, 0, 0, 0, 2'd0, 1, 3'b000));
    tbl.push_back(mk(3'b000, 12'h000, 0, 0, 1, 2'd0, 1, 3'b000));
    tbl.push_back(mk(3'b000, 12'h000, 0, 0, 1, 2'd1, 1, 3'b010));
    tbl.push_back(mk(3'b000, 12'h000, 0, 0, 1, 2'd2, 1, 3'b010));
    tbl.push_back(mk(3'b000, 12'h000, 0, 0, 1, 2'd0, 1, 3'b011));
    tbl.push_back(mk(3'b000, 12'h000, 0, 0, 1, 2'd2, 0, 3'b111));
    tbl.push_back(mk(3'b000, 12'h000, 0, 0, 0, 2'd2, 0, 3'b111));
    // Zero-point award: accepted, no effect.
    tbl.push_back(mk(3'b001, 12'h000, 0, 0, 0, 2'd2, 0, 3'b111));
    tbl.push_back(mk(3'b000, 12'h000, 0, 0, 0, 2'd2, 0, 3'b111));
    // Accept on req2 while req0 is granted; later valids on busy slots ignored.
    tbl.push_back(mk(3'b001, 12'h002, 0, 0, 0, 2'd2, 1, 3'b110));
    tbl.push_back(mk(3'b100, 12'h300, 0, 0, 1, 2'd0, 1, 3'b010));
    tbl.push_back(mk(3'b101, 12'hF0F, 0, 0, 1, 2'd2, 1, 3'b010));
    tbl.push_back(mk(3'b000, 12'h000, 0, 0, 1, 2'd0, 1, 3'b011));
    tbl.push_back(mk(3'b000, 12'h000, 0, 0, 1, 2'd2, 1, 3'b011));
    tbl.push_back(mk(3'b000, 12'h000, 0, 0, 1, 2'd2, 0, 3'b111));
    tbl.push_back(mk(3'b000, 12'h000, 0, 0, 0, 2'd2, 0, 3'b111));

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].v, tbl[i].p, tbl[i].h, tbl[i].c);
      chk($sformatf("vec%0d inc", i),   32'(score_inc), 32'(tbl[i].inc));
      chk($sformatf("vec%0d gid", i),   32'(grant_id),  32'(tbl[i].gid));
      chk($sformatf("vec%0d busy", i),  32'(busy),      32'(tbl[i].bsy));
      chk($sformatf("vec%0d ready", i), 32'(req_ready), 32'(tbl[i].rdy));
      if (i == 6) chk("score after single award", 32'(pulses), 32'd5);
    end
    chk("table pulse total", 32'(pulses), 32'd15);

    // Hold: 2 pulses, 4 held cycles, then the remaining 4 pulses.
    pulses = 0;
    cyc(3'b010, 12'h060, 1'b0, 1'b0);
    chk("hold accept busy", 32'(busy), 32'h1);
    cyc(3'b000, 12'h000, 1'b0, 1'b0);
    cyc(3'b000, 12'h000, 1'b0, 1'b0);
    chk("hold pre pulses", 32'(pulses), 32'd2);
    for (int n = 0; n < 4; n++) begin
      cyc(3'b000, 12'h000, 1'b1, 1'b0);
      chk($sformatf("held%0d inc", n), 32'(score_inc), 32'h0);
      chk($sformatf("held%0d busy", n), 32'(busy), 32'h1);
    end
    for (int n = 0; n < 4; n++) begin
      cyc(3'b000, 12'h000, 1'b0, 1'b0);
      chk($sformatf("resume%0d inc", n), 32'(score_inc), 32'h1);
      chk($sformatf("resume%0d gid", n), 32'(grant_id), 32'h1);
    end
    cyc(3'b000, 12'h000, 1'b0, 1'b0);
    chk("hold done inc", 32'(score_inc), 32'h0);
    chk("hold done busy", 32'(busy), 32'h0);
    chk("hold pulse total", 32'(pulses), 32'd6);

    // Clear after 2 pulses: remaining points dropped.
    pulses = 0;
    cyc(3'b010, 12'h060, 1'b0, 1'b0);
    cyc(3'b000, 12'h000, 1'b0, 1'b0);
    cyc(3'b000, 12'h000, 1'b0, 1'b0);
    cyc(3'b000, 12'h000, 1'b0, 1'b1);
    chk("clear inc", 32'(score_inc), 32'h0);
    chk("clear busy", 32'(busy), 32'h0);
    chk("clear ready1", 32'(req_ready[1]), 32'h1);
    for (int n = 0; n < 4; n++)
      cyc(3'b000, 12'h000, 1'b0, 1'b0);
    chk("clear pulse total", 32'(pulses), 32'd2);
`else
    // Paced: 3 points on req0 come out 3 cycles apart.
    cyc(3'b001, 12'h003, 1'b0, 1'b0);
    chk("pace accept busy", 32'(busy), 32'h1);
    for (int n = 1; n <= 12; n++) begin
      cyc(3'b000, 12'h000, 1'b0, 1'b0);
      chk($sformatf("pace c%0d inc", n), 32'(score_inc),
          32'((n == 1) || (n == 4) || (n == 7)));
    end
    chk("pace gid", 32'(grant_id), 32'h0);
    chk("pace busy end", 32'(busy), 32'h0);
    chk("pace pulse total", 32'(pulses), 32'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
